// File: rtl/instruction_prefetch_queue.sv
// Sequential instruction prefetch queue: one outstanding fetch, DEPTH-entry {pc, inst} FIFO, redirect flush.
// Optional performance counters (flushCount, stallCount) are enabled with `define PREFETCH_PERF_CNT_EN.
module instruction_prefetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic                     clock,
    input  logic                     reset,
    output logic                     memReq,
    output logic [31:0]              memAddr,
    input  logic                     memValid,
    input  logic [31:0]              memData,
    input  logic                     redirectValid,
    input  logic [31:0]              redirectPc,
    output logic                     instValid,
    output logic [31:0]              instData,
    output logic [31:0]              instPc,
    input  logic                     decodeReady,
    output logic [$clog2(DEPTH):0]   count
`ifdef PREFETCH_PERF_CNT_EN
    ,
    output logic [31:0]              flushCount,
    output logic [31:0]              stallCount
`endif
);

    localparam int unsigned PW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT, DISCARD} state_t;

    state_t          state_reg;
    logic [31:0]     fetch_pc_reg;
    logic [31:0]     req_pc_reg;
    logic [PW-1:0]   head_reg;
    logic [PW-1:0]   tail_reg;
    logic [PW:0]     count_reg;
    logic [31:0]     pc_mem   [DEPTH];
    logic [31:0]     data_mem [DEPTH];

    logic            in_flight;
    logic [PW+1:0]   occupied;
    logic            issue;
    logic            push;
    logic            pop;

    // A slot is reserved for the in-flight request, so the queue can never overflow on push.
    assign in_flight = (state_reg != IDLE);
    assign occupied  = {1'b0, count_reg} + (PW+2)'(in_flight);
    assign issue     = !redirectValid
                     && (state_reg == IDLE || (state_reg == WAIT && memValid))
                     && (occupied < (PW+2)'(DEPTH));
    assign push      = (state_reg == WAIT) && memValid && !redirectValid;
    assign pop       = instValid && decodeReady && !redirectValid;

    assign memReq    = issue && reset;
    assign memAddr   = fetch_pc_reg;
    assign instValid = (count_reg != '0);
    assign instData  = data_mem[head_reg];
    assign instPc    = pc_mem[head_reg];
    assign count     = count_reg;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg    <= IDLE;
            fetch_pc_reg <= RESET_PC;
            req_pc_reg   <= '0;
        end else if (redirectValid) begin
            fetch_pc_reg <= redirectPc & 32'hFFFF_FFFC;
            // A request still in the air must be swallowed before refetching.
            state_reg    <= (state_reg != IDLE && !memValid) ? DISCARD : IDLE;
        end else begin
            if (issue) begin
                fetch_pc_reg <= fetch_pc_reg + 32'd4;
                req_pc_reg   <= fetch_pc_reg;
            end
            case (state_reg)
                IDLE:    if (issue)    state_reg <= WAIT;
                WAIT:    if (memValid) state_reg <= issue ? WAIT : IDLE;
                DISCARD: if (memValid) state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem[i]   <= '0;
                data_mem[i] <= '0;
            end
        end else if (redirectValid) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else begin
            if (push) begin
                pc_mem[tail_reg]   <= req_pc_reg;
                data_mem[tail_reg] <= memData;
                tail_reg           <= tail_reg + PW'(1);
            end
            if (pop) begin
                head_reg <= head_reg + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + (PW+1)'(1);
                2'b01:   count_reg <= count_reg - (PW+1)'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

`ifdef PREFETCH_PERF_CNT_EN
    logic [31:0] flush_cnt_reg;
    logic [31:0] stall_cnt_reg;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            flush_cnt_reg <= '0;
            stall_cnt_reg <= '0;
        end else begin
            if (redirectValid) flush_cnt_reg <= flush_cnt_reg + 32'd1;
            if (!instValid)    stall_cnt_reg <= stall_cnt_reg + 32'd1;
        end
    end

    assign flushCount = flush_cnt_reg;
    assign stallCount = stall_cnt_reg;
`endif

endmodule

// File: tb/tb_instruction_prefetch_queue.sv
// Randomized bench for instruction_prefetch_queue against a queue-based model with a variable-latency memory.
// Perf counter checks are compiled when PREFETCH_PERF_CNT_EN is defined.
module tb_instruction_prefetch_queue;

    localparam int unsigned DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic        clock = 1'b0;
    logic        reset;
    logic        memReq;
    logic [31:0] memAddr;
    logic        memValid;
    logic [31:0] memData;
    logic        redirectValid;
    logic [31:0] redirectPc;
    logic        instValid;
    logic [31:0] instData;
    logic [31:0] instPc;
    logic        decodeReady;
    logic [2:0]  count;
`ifdef PREFETCH_PERF_CNT_EN
    logic [31:0] flushCount;
    logic [31:0] stallCount;
`endif

    instruction_prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clock(clock), .reset(reset),
        .memReq(memReq), .memAddr(memAddr), .memValid(memValid), .memData(memData),
        .redirectValid(redirectValid), .redirectPc(redirectPc),
        .instValid(instValid), .instData(instData), .instPc(instPc),
        .decodeReady(decodeReady), .count(count)
`ifdef PREFETCH_PERF_CNT_EN
        , .flushCount(flushCount), .stallCount(stallCount)
`endif
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
    } entry_t;

    int          n_total = 0;
    int          n_pass  = 0;
    int          cyc     = 0;
    int          lat     = 1;

    // memory side: single pending response
    logic        pend_valid = 1'b0;
    int          pend_due   = 0;
    logic [31:0] pend_data  = '0;

    // reference model
    entry_t      mq[$];
    logic [31:0] m_fetch;
    logic [31:0] m_req_pc;
    logic        m_out;
    logic        m_stale;
    logic [31:0] m_flush;
    logic [31:0] m_stall;

    logic        got_req;
    logic [31:0] got_addr;

    task automatic model_reset();
        mq.delete();
        m_fetch    = RESET_PC;
        m_req_pc   = '0;
        m_out      = 1'b0;
        m_stale    = 1'b0;
        m_flush    = '0;
        m_stall    = '0;
        pend_valid = 1'b0;
    endtask

    task automatic step(input logic rdy, input logic redir, input logic [31:0] rpc);
        logic exp_req;
        logic resp;
        logic do_pop;
        decodeReady   = rdy;
        redirectValid = redir;
        redirectPc    = rpc;
        resp          = pend_valid && (pend_due == cyc);
        memValid      = resp;
        memData       = resp ? pend_data : $urandom;
        #1;
        exp_req = !redir && (!m_out || (resp && !m_stale))
                && ((mq.size() + int'(m_out)) < DEPTH);
        n_total++;
        if (memReq !== exp_req) $display("FAIL memReq cyc=%0d got=%b exp=%b", cyc, memReq, exp_req);
        else n_pass++;
        if (exp_req) begin
            n_total++;
            if (memAddr !== m_fetch) $display("FAIL memAddr cyc=%0d got=%h exp=%h", cyc, memAddr, m_fetch);
            else n_pass++;
        end
        n_total++;
        if (count !== 3'(mq.size())) $display("FAIL count cyc=%0d got=%0d exp=%0d", cyc, count, mq.size());
        else n_pass++;
        n_total++;
        if (instValid !== (mq.size() != 0)) $display("FAIL instValid cyc=%0d got=%b exp=%b", cyc, instValid, mq.size() != 0);
        else n_pass++;
        if (mq.size() != 0) begin
            n_total++;
            if (instPc !== mq[0].pc || instData !== mq[0].data)
                $display("FAIL head cyc=%0d got pc=%h data=%h exp pc=%h data=%h", cyc, instPc, instData, mq[0].pc, mq[0].data);
            else n_pass++;
        end
`ifdef PREFETCH_PERF_CNT_EN
        n_total++;
        if (flushCount !== m_flush || stallCount !== m_stall)
            $display("FAIL perf cyc=%0d got flush=%0d stall=%0d exp flush=%0d stall=%0d", cyc, flushCount, stallCount, m_flush, m_stall);
        else n_pass++;
`endif
        // memory side reacts to what the DUT actually asked for
        got_req  = (memReq === 1'b1);
        got_addr = memAddr;
        if (resp) pend_valid = 1'b0;
        if (got_req) begin
            pend_valid = 1'b1;
            pend_due   = cyc + lat;
            pend_data  = memAddr + 32'h100;
        end
        // model advance
        if (redir) m_flush++;
        if (mq.size() == 0) m_stall++;
        if (redir) begin
            mq.delete();
            m_fetch = rpc & 32'hFFFF_FFFC;
            if (m_out && !resp) m_stale = 1'b1;
            else begin
                m_out   = 1'b0;
                m_stale = 1'b0;
            end
        end else begin
            do_pop = (mq.size() != 0) && rdy;
            if (do_pop) void'(mq.pop_front());
            if (resp && !m_stale) mq.push_back('{m_req_pc, memData});
            if (resp) begin
                m_out   = 1'b0;
                m_stale = 1'b0;
            end
            if (exp_req) begin
                m_out    = 1'b1;
                m_req_pc = m_fetch;
                m_fetch  = m_fetch + 32'd4;
            end
        end
        @(negedge clock);
        cyc++;
    endtask

    // Called at a negedge; reset spans one rising edge.
    task automatic test_reset();
        reset         = 1'b0;
        redirectValid = 1'b0;
        redirectPc    = '0;
        memValid      = 1'b0;
        memData       = '0;
        decodeReady   = 1'b0;
        model_reset();
        #1;
        n_total++;
        if (instValid !== 1'b0 || count !== 3'd0) $display("FAIL reset_state got valid=%b count=%0d exp valid=0 count=0", instValid, count);
        else n_pass++;
        n_total++;
        if (memReq !== 1'b0) $display("FAIL reset_memreq got=%b exp=0", memReq);
        else n_pass++;
        n_total++;
        if (instData !== 32'h0 || instPc !== 32'h0) $display("FAIL reset_storage got data=%h pc=%h exp 0", instData, instPc);
        else n_pass++;
`ifdef PREFETCH_PERF_CNT_EN
        n_total++;
        if (flushCount !== 32'd0 || stallCount !== 32'd0) $display("FAIL reset_perf got flush=%0d stall=%0d exp 0", flushCount, stallCount);
        else n_pass++;
`endif
        @(negedge clock);
        reset = 1'b1;
        cyc   = 0;
    endtask

    task automatic test_stream();
        logic [31:0] addrs [3];
        lat = 1;
        test_reset();
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 32'h0);
            addrs[i] = got_req ? got_addr : 32'hDEAD_BEEF;
        end
        n_total++;
        if (addrs[0] !== 32'h0 || addrs[1] !== 32'h4 || addrs[2] !== 32'h8)
            $display("FAIL stream_addrs got %h %h %h exp 0 4 8", addrs[0], addrs[1], addrs[2]);
        else n_pass++;
        for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 32'h0);
    endtask

    task automatic test_first_latency();
        lat = 1;
        test_reset();
        step(1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b0, 32'h0);
        n_total++;
        if (instValid !== 1'b1 || instPc !== 32'h0 || instData !== 32'h100)
            $display("FAIL first_head got valid=%b pc=%h data=%h exp 1 0 100", instValid, instPc, instData);
        else n_pass++;
    endtask

    task automatic test_full();
        logic [31:0] next_addr;
        lat = 1;
        test_reset();
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 32'h0);
        n_total++;
        if (count !== 3'd4) $display("FAIL full_count got=%0d exp=4", count);
        else n_pass++;
        n_total++;
        if (memReq !== 1'b0) $display("FAIL full_memreq got=%b exp=0", memReq);
        else n_pass++;
        next_addr = 32'hDEAD_BEEF;
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b0, 32'h0);
            if (got_req && next_addr == 32'hDEAD_BEEF) next_addr = got_addr;
        end
        n_total++;
        if (next_addr !== 32'h10) $display("FAIL full_resume got=%h exp=00000010", next_addr);
        else n_pass++;
    endtask

    task automatic test_redirect_stale();
        logic found;
        lat = 3;
        test_reset();
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            step(1'b1, 1'b0, 32'h0);
            if (got_req && got_addr == 32'h10) found = 1'b1;
        end
        n_total++;
        if (!found) $display("FAIL stale_setup got=no request to 10 exp=request");
        else n_pass++;
        step(1'b1, 1'b1, 32'h203);
        n_total++;
        if (count !== 3'd0) $display("FAIL stale_count got=%0d exp=0", count);
        else n_pass++;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            step(1'b1, 1'b0, 32'h0);
            if (got_req) begin
                found = 1'b1;
                n_total++;
                if (got_addr !== 32'h200) $display("FAIL stale_refetch got=%h exp=00000200", got_addr);
                else n_pass++;
            end
        end
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            step(1'b1, 1'b0, 32'h0);
            if (instValid === 1'b1) found = 1'b1;
        end
        n_total++;
        if (!found || instPc !== 32'h200) $display("FAIL stale_first_pc got valid=%b pc=%h exp pc=00000200", found, instPc);
        else n_pass++;
    endtask

    task automatic test_redirect_collision();
        logic found;
        lat = 1;
        test_reset();
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (count == 3'd2 && pend_valid && pend_due == cyc) found = 1'b1;
            else step(1'b0, 1'b0, 32'h0);
        end
        n_total++;
        if (!found) $display("FAIL collide_setup got=no count2+resp exp=setup");
        else n_pass++;
        step(1'b1, 1'b1, 32'h400);
        n_total++;
        if (count !== 3'd0) $display("FAIL collide_count got=%0d exp=0", count);
        else n_pass++;
        step(1'b1, 1'b0, 32'h0);
        n_total++;
        if (!got_req || got_addr !== 32'h400) $display("FAIL collide_refetch got req=%b addr=%h exp req=1 addr=00000400", got_req, got_addr);
        else n_pass++;
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 32'h0);
    endtask

    task automatic test_wrap();
        int reqs;
        logic [31:0] a [2];
        lat = 1;
        step(1'b1, 1'b1, 32'hFFFF_FFFC);
        reqs = 0;
        for (int i = 0; i < 12 && reqs < 2; i++) begin
            step(1'b1, 1'b0, 32'h0);
            if (got_req) begin
                a[reqs] = got_addr;
                reqs++;
            end
        end
        n_total++;
        if (reqs != 2 || a[0] !== 32'hFFFF_FFFC || a[1] !== 32'h0)
            $display("FAIL wrap got n=%0d a0=%h a1=%h exp fffffffc 00000000", reqs, a[0], a[1]);
        else n_pass++;
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 32'h0);
    endtask

    task automatic test_reset_mid();
        logic found;
        lat = 1;
        test_reset();
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (count == 3'd3) found = 1'b1;
            else step(1'b0, 1'b0, 32'h0);
        end
        n_total++;
        if (!found) $display("FAIL midreset_setup got=count %0d exp=3", count);
        else n_pass++;
        test_reset();
        step(1'b1, 1'b0, 32'h0);
        n_total++;
        if (!got_req || got_addr !== RESET_PC) $display("FAIL midreset_addr got req=%b addr=%h exp %h", got_req, got_addr, RESET_PC);
        else n_pass++;
`ifdef PREFETCH_PERF_CNT_EN
        step(1'b1, 1'b1, 32'h80);
        n_total++;
        if (flushCount !== 32'd1) $display("FAIL flush_one got=%0d exp=1", flushCount);
        else n_pass++;
`endif
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 32'h0);
    endtask

    task automatic test_random();
        for (int seg = 0; seg < 4; seg++) begin
            lat = 1 + (seg % 4);
            test_reset();
            for (int i = 0; i < 400; i++)
                step(($urandom % 4) != 0, ($urandom % 20) == 0, $urandom);
        end
    endtask

    initial begin
        reset = 1'b0;
        @(negedge clock);
        test_reset();
        test_first_latency();
        test_stream();
        test_full();
        test_redirect_stale();
        test_redirect_collision();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
